// File: rtl/dmem_if.sv
// dmem_if: MEM-stage data-memory access bus (address, store data, size codes, strobe, load result)
interface dmem_if #(
  parameter int ADDR_W = 7,
  parameter int XLEN = 32,
  parameter int SL_WIDTH = 3
);
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic mem_write;
  logic [SL_WIDTH-1:0] lwhb;
  logic [SL_WIDTH-1:0] swhb;
  logic [XLEN-1:0] rdata;
  modport master (output addr, wdata, mem_write, lwhb, swhb, input rdata);
  modport slave (input addr, wdata, mem_write, lwhb, swhb, output rdata);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: data memory with sized loads/stores, stepped debug word and sticky misalignment flag; define DMEM_ERR_EN to enable alignment checking
module dmem_responder #(
  parameter int ADDR_W = 7,
  parameter int XLEN = 32,
  parameter int SL_WIDTH = 3,
  parameter int DBG_ST = 0,
  parameter int DBG_END = 16
) (
  input logic clk,
  input logic rst,
  dmem_if.slave bus,
  input logic dbg_tick,
  input logic dbg_hold,
  input logic dbg_jump,
  output logic [XLEN-1:0] dm_data,
  output logic misalign_err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [15:0] st_cnt
);
  localparam int WI = ADDR_W - 2;
  localparam int DEPTH = 1 << WI;
  logic [XLEN-1:0] mem [DEPTH];
  logic [WI-1:0] wordIdx, idx, idxNext;
  logic [WI:0] idxInc;
  logic [1:0] lane;
  logic isSw, isSh, isSb, isLw, isLh, isLhu, isLb, isLbu;
  logic storeMis, loadMis, commit;
  logic [3:0] byteEn;
  logic [XLEN-1:0] wordSel, storeData;
  logic [15:0] halfSel;
  logic [7:0] byteSel;
  assign wordIdx = bus.addr[ADDR_W-1:2];
  assign lane = bus.addr[1:0];
  // decode size codes, alignment, store lanes, load extension and next scan index
  always_comb begin
    isSw = bus.swhb == SL_WIDTH'(1);
    isSh = bus.swhb == SL_WIDTH'(2);
    isSb = bus.swhb == SL_WIDTH'(3);
    isLw = bus.lwhb == SL_WIDTH'(1);
    isLh = bus.lwhb == SL_WIDTH'(2);
    isLb = bus.lwhb == SL_WIDTH'(3);
    isLhu = bus.lwhb == SL_WIDTH'(6);
    isLbu = bus.lwhb == SL_WIDTH'(7);
`ifdef DMEM_ERR_EN
    storeMis = bus.mem_write && ((isSw && lane != 2'b00) || (isSh && lane[0]));
    loadMis = (isLw && lane != 2'b00) || ((isLh || isLhu) && lane[0]);
`else
    storeMis = 1'b0;
    loadMis = 1'b0;
`endif
    commit = bus.mem_write && (isSw || isSh || isSb) && !storeMis;
    byteEn = isSw ? 4'hF : isSh ? (lane[1] ? 4'hC : 4'h3) : isSb ? 4'b0001 << lane : 4'h0;
    storeData = isSw ? bus.wdata : isSh ? {2{bus.wdata[15:0]}} : {4{bus.wdata[7:0]}};
    wordSel = mem[wordIdx];
    halfSel = lane[1] ? wordSel[31:16] : wordSel[15:0];
    byteSel = wordSel[8*lane +: 8];
    bus.rdata = loadMis ? '0 :
                isLw ? wordSel :
                (isLh || isLhu) ? {{16{isLh & halfSel[15]}}, halfSel} :
                (isLb || isLbu) ? {{24{isLb & byteSel[7]}}, byteSel} : '0;
    idxInc = {1'b0, idx} + 1'b1;
    idxNext = dbg_jump ? WI'(DBG_ST) :
              (dbg_tick && !dbg_hold) ? (idxInc == (WI+1)'(DBG_END) ? WI'(DBG_ST) : idxInc[WI-1:0]) : idx;
  end
  // memory array: cleared on reset, byte-lane writes on committed stores
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit) begin
      for (int b = 0; b < 4; b++) if (byteEn[b]) mem[wordIdx][8*b +: 8] <= storeData[8*b +: 8];
    end
  end
  // debug scan index and display word taken from the pre-update index
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= WI'(DBG_ST);
      dm_data <= '0;
    end else begin
      idx <= idxNext;
      dm_data <= {idx[3:0], mem[idx][27:0]};
    end
  end
  // saturating committed-store counter
  always_ff @(posedge clk) begin
    if (rst) st_cnt <= '0;
    else if (commit && st_cnt != 16'hFFFF) st_cnt <= st_cnt + 16'd1;
  end
`ifdef DMEM_ERR_EN
  // sticky misalignment flag; address latched only on the first offence
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_err <= 1'b0;
      err_addr <= '0;
    end else if ((storeMis || loadMis) && !misalign_err) begin
      misalign_err <= 1'b1;
      err_addr <= bus.addr;
    end
  end
`else
  assign misalign_err = 1'b0;
  assign err_addr = '0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of loads, stores, alignment handling, reset and debug scan
module tb_dmem_responder;
  localparam logic [2:0] NONE = 3'b000, LW = 3'b001, LH = 3'b010, LB = 3'b011, LHU = 3'b110, LBU = 3'b111;
  localparam logic [2:0] SW = 3'b001, SH = 3'b010, SB = 3'b011;
  logic clk = 1'b0;
  logic rst;
  logic dbg_tick, dbg_hold, dbg_jump;
  logic [31:0] dm_data;
  logic misalign_err;
  logic [6:0] err_addr;
  logic [15:0] st_cnt;
  int passed = 0;
  int total = 0;
  logic [31:0] dv [4] = '{32'hA1234567, 32'hB89ABCDE, 32'hC0FFEE01, 32'hD5555555};
  dmem_if #(.ADDR_W(7), .XLEN(32), .SL_WIDTH(3)) bus ();
  dmem_responder #(.ADDR_W(7), .XLEN(32), .SL_WIDTH(3), .DBG_ST(0), .DBG_END(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_tick(dbg_tick), .dbg_hold(dbg_hold),
    .dbg_jump(dbg_jump), .dm_data(dm_data), .misalign_err(misalign_err),
    .err_addr(err_addr), .st_cnt(st_cnt)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.addr = '0;
    bus.wdata = '0;
    bus.mem_write = 1'b0;
    bus.lwhb = NONE;
    bus.swhb = NONE;
    dbg_tick = 1'b0;
    dbg_hold = 1'b0;
    dbg_jump = 1'b0;
  endtask
  task automatic st(input logic [6:0] a, input logic [31:0] d, input logic [2:0] code, input logic mw);
    bus.addr = a;
    bus.wdata = d;
    bus.swhb = code;
    bus.mem_write = mw;
    bus.lwhb = NONE;
    cyc();
    idle();
  endtask
  task automatic ld(input logic [6:0] a, input logic [2:0] code);
    bus.addr = a;
    bus.lwhb = code;
    bus.swhb = NONE;
    bus.mem_write = 1'b0;
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    idle();
    cyc();
    rst = 1'b0;
    ld(7'h10, LW);
    total++; if (bus.rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=%h", bus.rdata, 32'h0); else passed++;
    total++; if (st_cnt !== 16'h0) $display("FAIL reset_st_cnt got=%h exp=%h", st_cnt, 16'h0); else passed++;
    total++; if (misalign_err !== 1'b0) $display("FAIL reset_misalign got=%b exp=0", misalign_err); else passed++;
    total++; if (err_addr !== 7'h0) $display("FAIL reset_err_addr got=%h exp=0", err_addr); else passed++;
    total++; if (dm_data !== 32'h0) $display("FAIL reset_dm_data got=%h exp=%h", dm_data, 32'h0); else passed++;
  endtask
  task automatic test_word();
    cyc();
    st(7'h08, 32'h12345678, SW, 1'b1);
    ld(7'h08, LW);
    total++; if (bus.rdata !== 32'h12345678) $display("FAIL lw_08 got=%h exp=%h", bus.rdata, 32'h12345678); else passed++;
    ld(7'h09, LBU);
    total++; if (bus.rdata !== 32'h00000056) $display("FAIL lbu_09 got=%h exp=%h", bus.rdata, 32'h56); else passed++;
    ld(7'h0B, LB);
    total++; if (bus.rdata !== 32'h00000012) $display("FAIL lb_0b got=%h exp=%h", bus.rdata, 32'h12); else passed++;
    total++; if (st_cnt !== 16'd1) $display("FAIL st_cnt_1 got=%0d exp=1", st_cnt); else passed++;
  endtask
  task automatic test_byte();
    cyc();
    st(7'h0C, 32'h0, SW, 1'b1);
    st(7'h0E, 32'h00000080, SB, 1'b1);
    ld(7'h0E, LB);
    total++; if (bus.rdata !== 32'hFFFFFF80) $display("FAIL lb_0e got=%h exp=%h", bus.rdata, 32'hFFFFFF80); else passed++;
    ld(7'h0E, LBU);
    total++; if (bus.rdata !== 32'h00000080) $display("FAIL lbu_0e got=%h exp=%h", bus.rdata, 32'h80); else passed++;
    ld(7'h0C, LW);
    total++; if (bus.rdata !== 32'h00800000) $display("FAIL lw_0c got=%h exp=%h", bus.rdata, 32'h00800000); else passed++;
  endtask
  task automatic test_half();
    cyc();
    st(7'h12, 32'h0000BEEF, SH, 1'b1);
    ld(7'h12, LH);
    total++; if (bus.rdata !== 32'hFFFFBEEF) $display("FAIL lh_12 got=%h exp=%h", bus.rdata, 32'hFFFFBEEF); else passed++;
    ld(7'h12, LHU);
    total++; if (bus.rdata !== 32'h0000BEEF) $display("FAIL lhu_12 got=%h exp=%h", bus.rdata, 32'h0000BEEF); else passed++;
    ld(7'h10, LW);
    total++; if (bus.rdata !== 32'hBEEF0000) $display("FAIL lw_10 got=%h exp=%h", bus.rdata, 32'hBEEF0000); else passed++;
    total++; if (st_cnt !== 16'd4) $display("FAIL st_cnt_4 got=%0d exp=4", st_cnt); else passed++;
  endtask
  task automatic test_no_write();
    cyc();
    st(7'h10, 32'hFFFFFFFF, NONE, 1'b1);
    st(7'h10, 32'h11111111, SW, 1'b0);
    ld(7'h10, LW);
    total++; if (bus.rdata !== 32'hBEEF0000) $display("FAIL nowrite_data got=%h exp=%h", bus.rdata, 32'hBEEF0000); else passed++;
    ld(7'h10, 3'b100);
    total++; if (bus.rdata !== 32'h0) $display("FAIL undef_load got=%h exp=0", bus.rdata); else passed++;
    total++; if (st_cnt !== 16'd4) $display("FAIL nowrite_cnt got=%0d exp=4", st_cnt); else passed++;
  endtask
  task automatic test_misalign();
    cyc();
    st(7'h04, 32'h00000011, SW, 1'b1);
    st(7'h05, 32'h000000AA, SW, 1'b1);
`ifdef DMEM_ERR_EN
    ld(7'h04, LW);
    total++; if (bus.rdata !== 32'h00000011) $display("FAIL mis_sw_suppressed got=%h exp=%h", bus.rdata, 32'h11); else passed++;
    total++; if (misalign_err !== 1'b1) $display("FAIL mis_flag got=%b exp=1", misalign_err); else passed++;
    total++; if (err_addr !== 7'h05) $display("FAIL mis_err_addr got=%h exp=05", err_addr); else passed++;
    total++; if (st_cnt !== 16'd5) $display("FAIL mis_st_cnt got=%0d exp=5", st_cnt); else passed++;
    cyc();
    ld(7'h07, LH);
    total++; if (bus.rdata !== 32'h0) $display("FAIL mis_lh_data got=%h exp=0", bus.rdata); else passed++;
    cyc();
    idle();
    total++; if (err_addr !== 7'h05) $display("FAIL mis_err_keep got=%h exp=05", err_addr); else passed++;
`else
    ld(7'h04, LW);
    total++; if (bus.rdata !== 32'h000000AA) $display("FAIL noerr_sw got=%h exp=%h", bus.rdata, 32'hAA); else passed++;
    total++; if (misalign_err !== 1'b0) $display("FAIL noerr_flag got=%b exp=0", misalign_err); else passed++;
    total++; if (err_addr !== 7'h00) $display("FAIL noerr_err_addr got=%h exp=0", err_addr); else passed++;
    total++; if (st_cnt !== 16'd6) $display("FAIL noerr_st_cnt got=%0d exp=6", st_cnt); else passed++;
    cyc();
    st(7'h07, 32'h00001234, SH, 1'b1);
    ld(7'h07, LH);
    total++; if (bus.rdata !== 32'h00001234) $display("FAIL noerr_lh got=%h exp=%h", bus.rdata, 32'h1234); else passed++;
    ld(7'h05, LW);
    total++; if (bus.rdata !== 32'h123400AA) $display("FAIL noerr_lw got=%h exp=%h", bus.rdata, 32'h123400AA); else passed++;
`endif
  endtask
  task automatic test_reset_drop();
    cyc();
    rst = 1'b1;
    bus.addr = 7'h08;
    bus.wdata = 32'hDEADBEEF;
    bus.swhb = SW;
    bus.mem_write = 1'b1;
    cyc();
    rst = 1'b0;
    idle();
    ld(7'h08, LW);
    total++; if (bus.rdata !== 32'h0) $display("FAIL rstdrop_data got=%h exp=0", bus.rdata); else passed++;
    total++; if (st_cnt !== 16'd0) $display("FAIL rstdrop_cnt got=%0d exp=0", st_cnt); else passed++;
    total++; if (misalign_err !== 1'b0) $display("FAIL rstdrop_flag got=%b exp=0", misalign_err); else passed++;
  endtask
  task automatic test_debug();
    int k;
    cyc();
    for (int i = 0; i < 4; i++) st(7'(i * 4), dv[i], SW, 1'b1);
    cyc();
    total++; if (dm_data !== {4'd0, dv[0][27:0]}) $display("FAIL dbg_idx0 got=%h exp=%h", dm_data, {4'd0, dv[0][27:0]}); else passed++;
    for (int n = 1; n <= 5; n++) begin
      k = n % 4;
      dbg_tick = 1'b1;
      cyc();
      dbg_tick = 1'b0;
      cyc();
      total++; if (dm_data !== {4'(k), dv[k][27:0]}) $display("FAIL dbg_step%0d got=%h exp=%h", n, dm_data, {4'(k), dv[k][27:0]}); else passed++;
    end
    dbg_tick = 1'b1;
    dbg_hold = 1'b1;
    cyc();
    idle();
    cyc();
    total++; if (dm_data !== {4'd1, dv[1][27:0]}) $display("FAIL dbg_hold got=%h exp=%h", dm_data, {4'd1, dv[1][27:0]}); else passed++;
    dbg_tick = 1'b1;
    dbg_jump = 1'b1;
    cyc();
    idle();
    cyc();
    total++; if (dm_data !== {4'd0, dv[0][27:0]}) $display("FAIL dbg_jump got=%h exp=%h", dm_data, {4'd0, dv[0][27:0]}); else passed++;
  endtask
  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_no_write();
    test_misalign();
    test_reset_drop();
    test_debug();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory target for the 5-stage pipeline's MEM-stage access port.
- Accepts byte address, store data, load/store size codes and the write strobe from MEM.
- Returns sign/zero-extended load data in the same cycle, so the pipeline captures it into its MEM/WB register at the next edge.
- Provides a stepped debug word for the seg7x16 display and sticky misalignment reporting.

Parameters:
- ADDR_W, 7, byte-address width; array depth is 2^(ADDR_W-2) 32-bit words.
- XLEN, 32, data width.
- SL_WIDTH, 3, width of the load/store size codes.
- DBG_ST, 0, first word index shown by the debug scan.
- DBG_END, 16, scan wraps to DBG_ST when the index reaches this value (exclusive).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- addr  in  ADDR_W  byte address from MEM stage.
- wdata  in  XLEN  store data; the low bytes carry sub-word data.
- mem_write  in  1  store strobe.
- lwhb  in  SL_WIDTH  load code: 000 none, 001 LW, 010 LH, 011 LB, 110 LHU, 111 LBU.
- swhb  in  SL_WIDTH  store code: 000 none, 001 SW, 010 SH, 011 SB.
- rdata  out  XLEN  load result (combinational).
- dbg_tick  in  1  one-cycle pulse that advances the debug scan.
- dbg_hold  in  1  freezes the scan index.
- dbg_jump  in  1  forces the scan index to DBG_ST.
- dm_data  out  XLEN  registered display word: {idx[3:0], mem[idx][27:0]}.
- misalign_err  out  1  sticky misaligned-access flag.
- err_addr  out  ADDR_W  address of the first misaligned access.
- st_cnt  out  16  saturating count of committed stores.

Behaviour:
- Reset, when rst=1 at posedge:
  - every memory word becomes 0;
  - scan idx becomes DBG_ST; dm_data becomes 0;
  - misalign_err, err_addr and st_cnt become 0.
  - A store presented in the same cycle as rst is dropped.
- Word index is addr[ADDR_W-1:2]. Lane is addr[1:0].
- Store commit: mem_write=1 and swhb≠000 and the access is aligned. The write happens at posedge.
  - SW writes the whole word.
  - SH writes lanes {addr[1],0} and {addr[1],1} from wdata[15:0].
  - SB writes lane addr[1:0] from wdata[7:0].
  - Other lanes are unchanged.
- Store with mem_write=1 and swhb=000: no write, not counted.
- A store is visible to loads from the cycle after its posedge. There is no same-cycle bypass; the pipeline never issues a load and a store in one cycle.
- Load (combinational), using the selected word W:
  - LW → W.
  - LH/LHU → half selected by addr[1], sign- or zero-extended.
  - LB/LBU → byte selected by addr[1:0], sign- or zero-extended.
  - lwhb=000 or an undefined code → rdata = 0.
- Alignment rules: word accesses need addr[1:0]=00; half accesses need addr[0]=0.
  - A misaligned store is suppressed.
  - A misaligned load returns 0.
- misalign_err is set at posedge on the first misaligned access. err_addr captures addr only on that 0→1 transition. Both stay set until rst.
- st_cnt increments once per committed store and saturates at 16'hFFFF.
- Debug scan, at posedge:
  - if dbg_jump=1: idx ← DBG_ST (highest priority);
  - else if dbg_tick=1 and dbg_hold=0: idx ← idx+1, and if the result equals DBG_END, idx ← DBG_ST.
  - dm_data ← {idx[3:0], mem[idx][27:0]} every cycle from the pre-update idx, so it reflects the current contents with 1-cycle latency.
- idx beyond depth: the index is truncated to the word-index width.

Optional Feature:
- Macro DMEM_ERR_EN.
- When defined: misalignment detection, suppression and the misalign_err/err_addr behaviour are exactly as above.
- When undefined:
  - no alignment check is performed;
  - SW/LW ignore addr[1:0];
  - SH/LH/LHU ignore addr[0];
  - all accesses commit normally;
  - misalign_err and err_addr are tied to 0.

Test Plan:
- rst=1 one cycle, then LW at addr 0x10 → rdata=0, st_cnt=0, misalign_err=0, dm_data=0 on the first post-reset cycle.
- SW 0x12345678 @0x08; next cycle LW @0x08 → 0x12345678; LBU @0x09 → 0x00000056; LB @0x0B → 0x00000012; st_cnt=1.
- SW 0 @0x0C, then SB 0x80 @0x0E, then LB @0x0E → 0xFFFFFF80; LBU → 0x00000080; LW @0x0C → 0x00800000.
- SH 0xBEEF @0x12, then LH @0x12 → 0xFFFFBEEF; LHU → 0x0000BEEF; LW @0x10 → 0xBEEF0000.
- With DMEM_ERR_EN: SW 0xAA @0x05 → word 1 unchanged, misalign_err=1, err_addr=0x05; a later LH @0x07 leaves err_addr=0x05 and returns 0.
- DBG_ST=0, DBG_END=4: fill words 0–3, pulse dbg_tick 4 times → dm_data idx field sequence 0,1,2,3,0. dbg_hold=1 with a tick → idx unchanged. dbg_jump together with a tick → idx=0.
